// File: rtl/z80_io_controller_pkg.sv
// Shared constants for the Z80 I/O controller: register offsets, wait FSM
// states and the interrupt priority encoder.
package z80_io_controller_pkg;

    localparam logic [2:0] REG_INDEX = 3'd0;
    localparam logic [2:0] REG_WAIT  = 3'd1;
    localparam logic [2:0] REG_MASK  = 3'd2;
    localparam logic [2:0] REG_PEND  = 3'd3;
    localparam logic [2:0] REG_VBASE = 3'd4;

    localparam logic [2:0] NO_IRQ_IDX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } wait_state_t;

    // Returns {valid, index} of the lowest set bit; index 7 when nothing is set.
    function automatic logic [3:0] lowest_idx(input logic [7:0] v);
        lowest_idx = {1'b0, NO_IRQ_IDX};
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = {1'b1, 3'(i)};
        end
    endfunction

endpackage

// File: rtl/z80_io_controller_if.sv
// Z80 CPU-side bus, chip-selects and interrupt lines of the I/O controller.
interface z80_io_controller_if #(
    parameter int N_SLOTS = 8,
    parameter int N_IRQ   = 4
);
    logic               i_m1_n;
    logic               i_iorq_n;
    logic               i_rd_n;
    logic               i_wr_n;
    logic [7:0]         i_addr;
    logic [7:0]         i_data;
    logic [7:0]         o_data;
    logic               o_data_oe;
    logic [N_SLOTS-1:0] o_cs_n;
    logic               o_wait_n;
    logic [N_IRQ-1:0]   i_irq;
    logic               o_int_n;

    modport master (
        output i_m1_n, i_iorq_n, i_rd_n, i_wr_n, i_addr, i_data, i_irq,
        input  o_data, o_data_oe, o_cs_n, o_wait_n, o_int_n
    );

    modport slave (
        input  i_m1_n, i_iorq_n, i_rd_n, i_wr_n, i_addr, i_data, i_irq,
        output o_data, o_data_oe, o_cs_n, o_wait_n, o_int_n
    );
endinterface

// File: rtl/z80_irq_prio.sv
// Edge-latched, maskable interrupt pending register with lowest-index priority
// and clear-on-acknowledge; a new edge always wins over a clear of the same bit.
module z80_irq_prio
    import z80_io_controller_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_mask,
    input  logic [N_IRQ-1:0] i_clr,
    input  logic             i_ack_cyc,
    input  logic             i_iorq_n,
    output logic [N_IRQ-1:0] o_pend,
    output logic             o_int_n,
    output logic [2:0]       o_vec_idx
);
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_irq_prev;
    logic             r_int_n;
    logic             r_ack_seen;
    logic             r_ack_valid;
    logic [2:0]       r_ack_idx;

    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_ack_clr;
    logic [7:0]       w_req;
    logic             w_valid;
    logic [2:0]       w_idx;

    assign w_set = i_irq & ~r_irq_prev & i_mask;

    always_comb begin
        w_req = '0;
        w_req[N_IRQ-1:0] = r_pend & i_mask;
        {w_valid, w_idx} = lowest_idx(w_req);
    end

    // The acknowledged source is released when IORQ rises at the end of the cycle.
    always_comb begin
        w_ack_clr = '0;
        if (r_ack_seen && r_ack_valid && i_iorq_n) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (r_ack_idx == 3'(i)) w_ack_clr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pend      <= '0;
            r_irq_prev  <= '0;
            r_int_n     <= 1'b1;
            r_ack_seen  <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_idx   <= NO_IRQ_IDX;
        end else begin
            r_irq_prev <= i_irq;
            r_pend     <= (r_pend & ~(i_clr | w_ack_clr)) | w_set;
            r_int_n    <= ~|(r_pend & i_mask);
            if (i_ack_cyc && !r_ack_seen) begin
                r_ack_seen  <= 1'b1;
                r_ack_valid <= w_valid;
                r_ack_idx   <= w_idx;
            end else if (i_iorq_n) begin
                r_ack_seen  <= 1'b0;
                r_ack_valid <= 1'b0;
            end
        end
    end

    // Before the first acknowledge edge the live encoder supplies the vector.
    assign o_vec_idx = r_ack_seen ? r_ack_idx : w_idx;
    assign o_pend    = r_pend;
    assign o_int_n   = r_int_n;

endmodule

// File: rtl/z80_io_controller.sv
// Z80 I/O slot decoder with per-slot programmable wait states and a mode-2
// interrupt controller whose registers occupy the top slot.
module z80_io_controller
    import z80_io_controller_pkg::*;
#(
    parameter int N_SLOTS = 8,
    parameter int N_IRQ   = 4,
    parameter int WAIT_W  = 3
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    z80_io_controller_if.slave  bus
);
    localparam int                    SLOT_BITS = $clog2(N_SLOTS);
    localparam logic [SLOT_BITS-1:0]  INT_SLOT  = SLOT_BITS'(N_SLOTS - 1);
    localparam logic [WAIT_W-1:0]     ONE_W     = WAIT_W'(1);

    logic [SLOT_BITS-1:0] r_index;
    logic [WAIT_W-1:0]    r_wait [N_SLOTS];
    logic [N_IRQ-1:0]     r_mask;
    logic [3:0]           r_vbase;
    logic                 r_wr_seen;
    wait_state_t          r_state;
    logic [WAIT_W-1:0]    r_cnt;
    logic                 r_wait_n;

    logic                 w_io_cyc;
    logic                 w_ack_cyc;
    logic [SLOT_BITS-1:0] w_slot;
    logic [2:0]           w_offset;
    logic                 w_int_sel;
    logic                 w_wr_commit;
    logic [N_IRQ-1:0]     w_pend_clr;
    logic [N_IRQ-1:0]     w_pend;
    logic                 w_int_n;
    logic [2:0]           w_vec_idx;
    logic [WAIT_W-1:0]    w_slot_wait;
    logic [7:0]           w_rd_data;
    logic [7:0]           w_data;
    logic                 w_oe;
    logic [N_SLOTS-1:0]   w_cs_n;
    logic                 w_unused;

    assign w_io_cyc    = ~bus.i_iorq_n & bus.i_m1_n;
    assign w_ack_cyc   = ~bus.i_iorq_n & ~bus.i_m1_n;
    assign w_slot      = bus.i_addr[7 -: SLOT_BITS];
    assign w_offset    = bus.i_addr[2:0];
    assign w_int_sel   = w_io_cyc & (w_slot == INT_SLOT);
    assign w_wr_commit = w_int_sel & ~bus.i_wr_n & ~r_wr_seen;
    assign w_pend_clr  = (w_wr_commit && w_offset == REG_PEND) ? bus.i_data[N_IRQ-1:0] : '0;
    assign w_slot_wait = r_wait[w_slot];
    assign w_unused    = &{1'b0, bus.i_addr, bus.i_data};

    z80_irq_prio #(.N_IRQ(N_IRQ)) u_irq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_irq     (bus.i_irq),
        .i_mask    (r_mask),
        .i_clr     (w_pend_clr),
        .i_ack_cyc (w_ack_cyc),
        .i_iorq_n  (bus.i_iorq_n),
        .o_pend    (w_pend),
        .o_int_n   (w_int_n),
        .o_vec_idx (w_vec_idx)
    );

    always_comb begin
        w_rd_data = '0;
        case (w_offset)
            REG_INDEX: w_rd_data[SLOT_BITS-1:0] = r_index;
            REG_WAIT:  w_rd_data[WAIT_W-1:0]    = r_wait[r_index];
            REG_MASK:  w_rd_data[N_IRQ-1:0]     = r_mask;
            REG_PEND:  w_rd_data[N_IRQ-1:0]     = w_pend;
            REG_VBASE: w_rd_data[7:4]           = r_vbase;
            default:   w_rd_data = '0;
        endcase
    end

    // Decode outputs are forced inactive while reset is held.
    always_comb begin
        w_cs_n = '1;
        w_data = '0;
        w_oe   = 1'b0;
        if (i_reset_n) begin
            for (int s = 0; s < N_SLOTS - 1; s++) begin
                if (w_io_cyc && w_slot == SLOT_BITS'(s)) w_cs_n[s] = 1'b0;
            end
            if (w_ack_cyc) begin
                w_oe   = 1'b1;
                w_data = {r_vbase, w_vec_idx, 1'b0};
            end else if (w_int_sel && !bus.i_rd_n) begin
                w_oe   = 1'b1;
                w_data = w_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_index   <= '0;
            r_mask    <= '0;
            r_vbase   <= '0;
            r_wr_seen <= 1'b0;
            for (int s = 0; s < N_SLOTS; s++) r_wait[s] <= '0;
        end else begin
            if (bus.i_iorq_n)     r_wr_seen <= 1'b0;
            else if (w_wr_commit) r_wr_seen <= 1'b1;
            if (w_wr_commit) begin
                case (w_offset)
                    REG_INDEX: r_index <= bus.i_data[SLOT_BITS-1:0];
                    REG_WAIT:  if (r_index != INT_SLOT) r_wait[r_index] <= bus.i_data[WAIT_W-1:0];
                    REG_MASK:  r_mask  <= bus.i_data[N_IRQ-1:0];
                    REG_VBASE: r_vbase <= bus.i_data[7:4];
                    default:   ;
                endcase
            end
        end
    end

    // WAIT is held low for exactly W cycles starting the cycle after IORQ is first seen.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wait_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_io_cyc) begin
                        if (w_slot_wait != '0) begin
                            r_state  <= ST_COUNT;
                            r_cnt    <= w_slot_wait - ONE_W;
                            r_wait_n <= 1'b0;
                        end else begin
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_COUNT: begin
                    if (bus.i_iorq_n) begin
                        r_state  <= ST_IDLE;
                        r_wait_n <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state  <= ST_DONE;
                        r_wait_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - ONE_W;
                    end
                end
                ST_DONE: begin
                    if (bus.i_iorq_n) r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wait_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_cs_n    = w_cs_n;
    assign bus.o_data    = w_data;
    assign bus.o_data_oe = w_oe;
    assign bus.o_wait_n  = r_wait_n;
    assign bus.o_int_n   = w_int_n;

endmodule
